// File: rtl/cve2_restart_pkg.sv
// rtl/cve2_restart_pkg.sv - shared types and constants for the core restart controller
//
// Purpose: FSM state encoding, the RELEASE phase length and a counter-width
//          helper shared by the restart controller and its testbench.
// Ports:   none (package).

package cve2_restart_pkg;

   typedef enum logic [2:0] {
      ST_RUN     = 3'd0,
      ST_DRAIN   = 3'd1,
      ST_CLEAR   = 3'd2,
      ST_RELEASE = 3'd3,
      ST_HALTED  = 3'd4
   } restart_state_e;

   // The reset isolator has a 2-stage clear pipeline; RELEASE waits it out
   // before fetch is re-enabled.
   localparam int unsigned RELEASE_CYCLES = 2;

   localparam int unsigned OUTSTANDING_MAX = 7;

   // Bits needed to count 0 .. n-1 (at least 1 bit).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cve2_core_restart_ctrl_if.sv
// rtl/cve2_core_restart_ctrl_if.sv - core instruction/data bus handshake bundle
//
// Purpose: groups the core's instruction and data bus handshake signals that
//          the restart controller monitors.
// Ports (signals):
//   instr_req_i, instr_gnt_i, instr_rvalid_i - instruction port handshake
//   data_req_i,  data_gnt_i,  data_rvalid_i  - data port handshake
// Modports:
//   master - the side driving the bus signals (core / bus fabric)
//   slave  - the observing side (restart controller)

interface cve2_core_restart_ctrl_if;

   logic instr_req_i;
   logic instr_gnt_i;
   logic instr_rvalid_i;
   logic data_req_i;
   logic data_gnt_i;
   logic data_rvalid_i;

   modport master (
      output instr_req_i, instr_gnt_i, instr_rvalid_i,
      output data_req_i,  data_gnt_i,  data_rvalid_i
   );

   modport slave (
      input instr_req_i, instr_gnt_i, instr_rvalid_i,
      input data_req_i,  data_gnt_i,  data_rvalid_i
   );

endinterface

// File: rtl/cve2_outstanding_cnt.sv
// rtl/cve2_outstanding_cnt.sv - saturating outstanding-transaction counter for one bus port
//
// Purpose: counts requests accepted (req && gnt) but not yet answered (rvalid).
// Ports:
//   clk_i, rst_i   - clock, synchronous active-high reset
//   clr_i          - force the count to zero at the next edge
//   req_i, gnt_i   - request handshake of the monitored port
//   rvalid_i       - response valid of the monitored port
//   cnt_next_o     - count after this cycle's handshake (before clr_i)
//   underflow_o    - response seen with nothing outstanding (this cycle)

module cve2_outstanding_cnt
   import cve2_restart_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       clr_i,
   input  logic       req_i,
   input  logic       gnt_i,
   input  logic       rvalid_i,
   output logic [2:0] cnt_next_o,
   output logic       underflow_o
);

   localparam logic [2:0] CNT_MAX = 3'(OUTSTANDING_MAX);

   logic [2:0] cnt_q;
   logic       accept;

   assign accept = req_i & gnt_i;

   // A same-cycle accept and response cancel out. An underflow is only a
   // response that arrives with nothing outstanding and no accept to pair with.
   always_comb begin
      cnt_next_o  = cnt_q;
      underflow_o = 1'b0;
      if (accept && !rvalid_i) begin
         if (cnt_q != CNT_MAX) begin
            cnt_next_o = cnt_q + 3'd1;
         end
      end else if (rvalid_i && !accept) begin
         if (cnt_q == 3'd0) begin
            underflow_o = 1'b1;
         end else begin
            cnt_next_o = cnt_q - 3'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         cnt_q <= 3'd0;
      end else begin
         cnt_q <= cnt_next_o;
      end
   end

endmodule

// File: rtl/cve2_core_restart_ctrl.sv
// rtl/cve2_core_restart_ctrl.sv - drain / clear / release sequencer for restarting or halting the core
//
// Purpose: on a restart or halt request, stops fetch, waits for the core's bus
//          traffic to drain (or times out), pulses the reset isolator clear
//          for HOLD_CYCLES, then either releases the core back to RUN or parks
//          it in HALTED until resumed.
// Ports:
//   clk_i, rst_i          - clock, synchronous active-high reset
//   restart_i, halt_i     - request pulses (accepted in RUN)
//   resume_i              - leave HALTED
//   bus                   - monitored instr/data handshakes (slave modport)
//   clear_no              - isolator clear, active-low
//   fetch_enable_o        - core fetch enable
//   busy_o, halted_o      - sequencer status
//   done_o                - one-cycle pulse on entry into RUN
//   timeout_o             - sticky: last drain was cut short by timeout
//   proto_err_o           - sticky: response seen with nothing outstanding

module cve2_core_restart_ctrl
   import cve2_restart_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES   = 4,
   parameter int unsigned DRAIN_TIMEOUT = 1024,
   parameter bit          BOOT_HALTED   = 1'b0
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      restart_i,
   input  logic                      halt_i,
   input  logic                      resume_i,
   cve2_core_restart_ctrl_if.slave   bus,
   output logic                      clear_no,
   output logic                      fetch_enable_o,
   output logic                      busy_o,
   output logic                      halted_o,
   output logic                      done_o,
   output logic                      timeout_o,
   output logic                      proto_err_o
);

   localparam int unsigned HOLD_W = cnt_width(HOLD_CYCLES);
   localparam int unsigned TO_W   = cnt_width(DRAIN_TIMEOUT);
   localparam int unsigned REL_W  = cnt_width(RELEASE_CYCLES);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(DRAIN_TIMEOUT - 1);
   localparam logic [REL_W-1:0]  REL_LAST  = REL_W'(RELEASE_CYCLES - 1);

   restart_state_e    state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [REL_W-1:0]  rel_q, rel_d;
   logic [TO_W-1:0]   to_q, to_d;
   logic              halt_pend_q, halt_pend_d;
   logic              done_q, done_d;
   logic              timeout_q, proto_err_q;
   logic              flags_clr, timeout_set;

   logic [2:0] instr_cnt_next, data_cnt_next;
   logic       instr_underflow, data_underflow;
   logic       cnt_clr;
   logic       drained;

   // Counts are zero for the whole CLEAR phase, including its first cycle.
   assign cnt_clr = (state_d == ST_CLEAR);

   cve2_outstanding_cnt u_instr_cnt (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clr_i       (cnt_clr),
      .req_i       (bus.instr_req_i),
      .gnt_i       (bus.instr_gnt_i),
      .rvalid_i    (bus.instr_rvalid_i),
      .cnt_next_o  (instr_cnt_next),
      .underflow_o (instr_underflow)
   );

   cve2_outstanding_cnt u_data_cnt (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clr_i       (cnt_clr),
      .req_i       (bus.data_req_i),
      .gnt_i       (bus.data_gnt_i),
      .rvalid_i    (bus.data_rvalid_i),
      .cnt_next_o  (data_cnt_next),
      .underflow_o (data_underflow)
   );

   // Quiet means nothing left outstanding after this cycle's handshakes and no
   // request still waiting for its grant on either port.
   assign drained = (instr_cnt_next == 3'd0) && (data_cnt_next == 3'd0) &&
                    !(bus.instr_req_i && !bus.instr_gnt_i) &&
                    !(bus.data_req_i  && !bus.data_gnt_i);

   always_comb begin
      state_d        = state_q;
      hold_d         = hold_q;
      rel_d          = rel_q;
      to_d           = to_q;
      halt_pend_d    = halt_pend_q;
      done_d         = 1'b0;
      flags_clr      = 1'b0;
      timeout_set    = 1'b0;
      clear_no       = 1'b1;
      fetch_enable_o = 1'b0;
      busy_o         = 1'b0;
      halted_o       = 1'b0;

      unique case (state_q)
         ST_RUN: begin
            fetch_enable_o = 1'b1;
            // A halt that arrived during the previous sequence is honoured
            // here as if it had just been requested.
            if (halt_i || halt_pend_q) begin
               state_d     = ST_DRAIN;
               halt_pend_d = 1'b1;
               flags_clr   = 1'b1;
               to_d        = '0;
            end else if (restart_i) begin
               state_d     = ST_DRAIN;
               halt_pend_d = 1'b0;
               flags_clr   = 1'b1;
               to_d        = '0;
            end
         end

         ST_DRAIN: begin
            busy_o = 1'b1;
            to_d   = to_q + TO_W'(1);
            if (halt_i) begin
               halt_pend_d = 1'b1;
            end
            if (drained) begin
               state_d = ST_CLEAR;
               hold_d  = HOLD_LAST;
            end else if (to_q == TO_LAST) begin
               state_d     = ST_CLEAR;
               hold_d      = HOLD_LAST;
               timeout_set = 1'b1;
            end
         end

         ST_CLEAR: begin
            clear_no = 1'b0;
            busy_o   = 1'b1;
            if (halt_i) begin
               halt_pend_d = 1'b1;
            end
            if (hold_q == '0) begin
               state_d = (halt_pend_q || halt_i) ? ST_HALTED : ST_RELEASE;
               rel_d   = REL_LAST;
            end else begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end

         ST_RELEASE: begin
            busy_o = 1'b1;
            if (halt_i) begin
               halt_pend_d = 1'b1;
            end
            if (rel_q == '0) begin
               state_d = ST_RUN;
               done_d  = 1'b1;
            end else begin
               rel_d = rel_q - REL_W'(1);
            end
         end

         ST_HALTED: begin
            clear_no = 1'b0;
            halted_o = 1'b1;
            if (resume_i) begin
               state_d     = ST_RELEASE;
               rel_d       = REL_LAST;
               halt_pend_d = 1'b0;
            end
         end

         default: begin
            state_d = ST_CLEAR;
            hold_d  = HOLD_LAST;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_CLEAR;
         hold_q      <= HOLD_LAST;
         rel_q       <= '0;
         to_q        <= '0;
         halt_pend_q <= BOOT_HALTED;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         rel_q       <= rel_d;
         to_q        <= to_d;
         halt_pend_q <= halt_pend_d;
         done_q      <= done_d;
         // A new event in the same cycle as the clear still gets recorded.
         timeout_q   <= timeout_set | (timeout_q & ~flags_clr);
         proto_err_q <= instr_underflow | data_underflow | (proto_err_q & ~flags_clr);
      end
   end

   assign done_o      = done_q;
   assign timeout_o   = timeout_q;
   assign proto_err_o = proto_err_q;

endmodule

// File: doc/cve2_core_restart_ctrl.md
CVE2_CORE_RESTART_CTRL -- requirements
Module: cve2_core_restart_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4, cycles clear_no is held low (min 1).
REQ-002 SHALL have parameter DRAIN_TIMEOUT, default 1024, max cycles spent draining before forced clear (min 1).
REQ-003 SHALL have parameter BOOT_HALTED, default 0; 1 means the core stays halted after reset until resume_i.
REQ-004 SHALL have ports: clk_i input 1 clock; rst_i input 1 reset, synchronous, active-high.
REQ-005 SHALL have ports: restart_i input 1 restart request pulse; halt_i input 1 halt request pulse; resume_i input 1 resume-from-halt pulse.
REQ-006 SHALL have bus-side monitor inputs: instr_req_i, instr_gnt_i, instr_rvalid_i, data_req_i, data_gnt_i, data_rvalid_i, each 1 bit.
REQ-007 SHALL have outputs: clear_no 1 (to reset isolator clear input, active-low); fetch_enable_o 1 (core fetch enable).
REQ-008 SHALL have outputs: busy_o 1; halted_o 1; done_o 1 (one-cycle pulse); timeout_o 1 (sticky); proto_err_o 1 (sticky).

Function
REQ-009 SHALL implement FSM states RUN, DRAIN, CLEAR, RELEASE, HALTED.
REQ-010 SHALL track outstanding count per port (3-bit): +1 on req&&gnt, -1 on rvalid, unchanged when both occur in the same cycle.
REQ-011 SHALL saturate each count at 7; rvalid at count 0 SHALL leave it 0 and set proto_err_o.
REQ-012 In RUN: clear_no=1, fetch_enable_o=1, busy_o=0; restart_i or halt_i moves to DRAIN next cycle.
REQ-013 halt_i and restart_i in the same cycle: halt wins; a halt_i during DRAIN/CLEAR/RELEASE SHALL set halt_pending.
REQ-014 restart_i outside RUN SHALL be ignored; resume_i outside HALTED SHALL be ignored.
REQ-015 In DRAIN: fetch_enable_o=0, clear_no=1, busy_o=1; timeout counter increments each cycle.
REQ-016 DRAIN exits to CLEAR when both counts are 0 and no req is pending without gnt (req&&!gnt) on either port.
REQ-017 DRAIN SHALL also exit to CLEAR when the timeout counter reaches DRAIN_TIMEOUT-1, setting timeout_o.
REQ-018 In CLEAR: clear_no=0, fetch_enable_o=0, busy_o=1; held exactly HOLD_CYCLES cycles; outstanding counts forced to 0.
REQ-019 CLEAR exits to HALTED if halt_pending, else to RELEASE.
REQ-020 In RELEASE: clear_no=1, fetch_enable_o=0, busy_o=1 for exactly 2 cycles, covering the isolator's 2-stage clear pipeline; then RUN with done_o=1 for 1 cycle.
REQ-021 In HALTED: clear_no=0, fetch_enable_o=0, halted_o=1, busy_o=0; resume_i moves to RELEASE and clears halt_pending.
REQ-022 timeout_o and proto_err_o SHALL clear only on reset or on a restart_i/halt_i accepted in RUN.
REQ-023 Monitor inputs SHALL be registered nowhere; counts update in the same cycle as the handshake.

Reset
REQ-024 On rst_i: state=CLEAR with hold counter loaded, clear_no=0, fetch_enable_o=0, busy_o=1, done_o=0, halted_o=0, timeout_o=0, proto_err_o=0, counts=0, halt_pending=BOOT_HALTED.
REQ-025 rst_i asserted mid-operation SHALL abort any state and re-enter the reset state the next cycle.
REQ-026 After reset, the post-CLEAR path follows REQ-019 (HALTED when BOOT_HALTED=1), and done_o SHALL pulse on the first entry into RUN.

Structure
REQ-027 SHALL define the FSM state enum and the RELEASE length constant (2) in shared package cve2_restart_pkg.
REQ-028 SHALL use one sub-module, cve2_outstanding_cnt, instantiated twice (instr and data), implementing REQ-010/011.

Verification
REQ-029 Reset, HOLD_CYCLES=4, BOOT_HALTED=0 -> clear_no low 4 cycles after reset deassertion, fetch_enable_o rises 2 cycles after clear_no, done_o pulses once.
REQ-030 RUN, data outstanding=2, restart_i; rvalids at +3 and +5 -> CLEAR entered the cycle after the second rvalid, timeout_o=0.
REQ-031 DRAIN_TIMEOUT=8, instr outstanding=1, no rvalid -> CLEAR after 8 DRAIN cycles, timeout_o=1, count=0 in CLEAR.
REQ-032 halt_i and restart_i in the same cycle -> HALTED after CLEAR, halted_o=1, clear_no=0; resume_i -> RELEASE 2 cycles -> RUN.
REQ-033 data_rvalid_i with count 0 -> proto_err_o=1, count stays 0; simultaneous req&&gnt and rvalid at count 1 -> count stays 1.
REQ-034 rst_i pulsed during DRAIN -> next cycle state=CLEAR, timeout_o=0, proto_err_o=0, all counts 0.
